// File: rtl/vram_scanout_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_scanout_reader_pkg
// Description : Shared types and constants for the VRAM scanout read path.
//               The ILI9341 colour type, the scanout FSM states and the
//               default VRAM geometry live here.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_scanout_reader_pkg;

    // RGB565 pixel as consumed by the ILI9341 pixel/SPI path
    localparam int ILI9341_COLOR_W = 16;
    typedef logic [ILI9341_COLOR_W-1:0] ILI9341_color_t;

    // Default panel geometry in portrait orientation
    localparam int DEFAULT_DISPLAY_WIDTH  = 240;
    localparam int DEFAULT_DISPLAY_HEIGHT = 320;

    // VRAM length in pixels and the address width that covers it
    localparam int VRAM_L      = DEFAULT_DISPLAY_WIDTH * DEFAULT_DISPLAY_HEIGHT;
    localparam int VRAM_ADDR_W = $clog2(VRAM_L);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scanout_state_t;

    // Bits needed to hold an occupancy count from 0 to depth inclusive
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_scanout_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_scanout_reader_if
// Description : Block RAM read port plus valid/ready pixel stream between the
//               scanout reader (master) and its VRAM/sink environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_scanout_reader_if
    import vram_scanout_reader_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = ILI9341_COLOR_W
) ();

    logic [ADDR_W-1:0] vram_rd_addr;
    logic [DATA_W-1:0] vram_rd_data;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;
    logic              pixel_ready;
    logic              pixel_first;
    logic              pixel_last;

    modport master (
        output vram_rd_addr,
        input  vram_rd_data,
        output pixel_data,
        output pixel_valid,
        input  pixel_ready,
        output pixel_first,
        output pixel_last
    );

    modport slave (
        input  vram_rd_addr,
        output vram_rd_data,
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready,
        input  pixel_first,
        input  pixel_last
    );

endinterface
`default_nettype wire

// File: rtl/vram_scanout_reader_pixel_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tag_fifo
// Description : Small synchronous FIFO of {pixel, first, last} with an
//               occupancy count. Head entry is presented combinationally and
//               stays stable until popped. Simultaneous push/pop is legal
//               even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tag_fifo
    import vram_scanout_reader_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 2,
    localparam int CNT_W  = fifo_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_first,
    input  logic              i_last,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_first,
    output logic              o_last,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_ENT_W = DATA_W + 2;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Popping an empty FIFO is ignored so the count can never underflow
    assign w_pop  = i_pop && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    assign o_data  = w_head[c_ENT_W-1:2];
    assign o_first = w_head[1];
    assign o_last  = w_head[0];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= {i_data, i_first, i_last};
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : vram_scanout_reader
// Description : Read-side VRAM master. On start it walks VRAM row-major,
//               absorbs the 1-cycle block RAM latency through a tagged FIFO
//               and streams pixels over valid/ready with full backpressure.
//               Optional macro CURSOR_OVERLAY_EN adds crosshair overlay ports.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_scanout_reader
    import vram_scanout_reader_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEFAULT_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEFAULT_DISPLAY_HEIGHT,
    parameter int VRAM_W         = ILI9341_COLOR_W,
    parameter int FIFO_DEPTH     = 2
`ifdef CURSOR_OVERLAY_EN
    ,
    parameter ILI9341_color_t CURSOR_COLOR = 16'hF800
`endif
) (
    vram_scanout_reader_if.master bus,
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic start,
    output logic busy,
    output logic frame_done
`ifdef CURSOR_OVERLAY_EN
    ,
    input  logic [7:0] cursor_x,
    input  logic [8:0] cursor_y,
    input  logic       cursor_valid
`endif
);

    localparam int c_PIX    = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int c_ADDR_W = (c_PIX > 1) ? $clog2(c_PIX) : 1;
    localparam int c_X_W    = (DISPLAY_WIDTH > 1) ? $clog2(DISPLAY_WIDTH) : 1;
    localparam int c_Y_W    = (DISPLAY_HEIGHT > 1) ? $clog2(DISPLAY_HEIGHT) : 1;
    localparam int c_CNT_W  = fifo_cnt_w(FIFO_DEPTH);

    scanout_state_t      r_state;
    scanout_state_t      w_state_nxt;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_X_W-1:0]    r_x;
    logic [c_Y_W-1:0]    r_y;
    logic                r_inflight;
    logic                r_inf_first;
    logic                r_inf_last;
    logic                w_issue;
    logic                w_pop;
    logic                w_addr_last;
    logic [31:0]         w_occ;
    logic [31:0]         w_cap;
    logic [VRAM_W-1:0]   w_push_data;
    logic [c_CNT_W-1:0]  w_count;

    assign w_pop       = bus.pixel_valid && bus.pixel_ready;
    assign w_addr_last = (r_x == c_X_W'(DISPLAY_WIDTH - 1)) && (r_y == c_Y_W'(DISPLAY_HEIGHT - 1));

    // Occupancy after this cycle must leave room for the read being issued
    assign w_occ   = 32'(w_count) + 32'(r_inflight);
    assign w_cap   = 32'(FIFO_DEPTH) + 32'(w_pop);
    assign w_issue = ena && (r_state == ISSUE) && (w_occ < w_cap);

    assign bus.vram_rd_addr = r_addr;
    assign busy             = (r_state != IDLE);
    assign frame_done       = (r_state == DONE);

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is honoured only in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = ISSUE;
            ISSUE:   if (w_issue && w_addr_last) w_state_nxt = DRAIN;
            DRAIN:   if ((w_count == '0) && !r_inflight) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address and raster counters; the final address is held rather than wrapped
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (w_issue && !w_addr_last) begin
            r_addr <= r_addr + c_ADDR_W'(1);
            if (r_x == c_X_W'(DISPLAY_WIDTH - 1)) begin
                r_x <= '0;
                r_y <= r_y + c_Y_W'(1);
            end else begin
                r_x <= r_x + c_X_W'(1);
            end
        end
    end

    // In-flight read tracking: tags travel with the read until its data returns
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_inflight  <= 1'b0;
            r_inf_first <= 1'b0;
            r_inf_last  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_first <= (r_addr == '0);
                r_inf_last  <= w_addr_last;
            end
        end
    end

`ifdef CURSOR_OVERLAY_EN
    logic r_inf_hit;
    logic w_hit;

    assign w_hit = cursor_valid &&
                   ((32'(r_x) == 32'(cursor_x)) || (32'(r_y) == 32'(cursor_y)));

    // Crosshair decision is taken with the cursor as it stands at issue time
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_inf_hit <= 1'b0;
        end else if (w_issue) begin
            r_inf_hit <= w_hit;
        end
    end

    assign w_push_data = r_inf_hit ? VRAM_W'(CURSOR_COLOR) : bus.vram_rd_data;
`else
    assign w_push_data = bus.vram_rd_data;
`endif

    pixel_tag_fifo #(
        .DATA_W (VRAM_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_first (r_inf_first),
        .i_last  (r_inf_last),
        .i_pop   (w_pop),
        .o_data  (bus.pixel_data),
        .o_first (bus.pixel_first),
        .o_last  (bus.pixel_last),
        .o_valid (bus.pixel_valid),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_vram_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_scanout_reader
// Description : Self-checking bench for vram_scanout_reader on a 4x3 frame
//               with VRAM preloaded as value = address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_scanout_reader;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int NPIX  = W * H;
    localparam int DEPTH = 2;
    localparam int NCYC  = 60;

    typedef struct {
        logic [3:0] ready_mask;   // pixel_ready in cycle c is ready_mask[c % 4]
        int         ena_from;     // first cycle with ena low
        int         ena_len;      // number of ena-low cycles (0 = none)
        int         repulse_at;   // cycle of an extra start pulse (0 = none)
        int         rst_at;       // cycle in which rstb is pulled low (0 = none)
        int         exp_first;    // cycle of first pixel_valid
        int         exp_done;     // cycle of frame_done (0 = not checked)
        int         exp_done_cnt; // number of frame_done pulses
    } vec_t;

    logic clk;
    logic rstb;
    logic ena;
    logic start;
    logic busy;
    logic frame_done;
    logic [7:0] cursor_x;
    logic [8:0] cursor_y;
    logic       cursor_valid;

    logic [15:0] vram_mem [16];
    logic [17:0] sb [$];
    vec_t        vecs [7];

    int n_checks = 0;
    int n_errors = 0;

    vram_scanout_reader_if #(.ADDR_W(4), .DATA_W(16)) sbus ();

    vram_scanout_reader #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .VRAM_W         (16),
        .FIFO_DEPTH     (DEPTH)
`ifdef CURSOR_OVERLAY_EN
        ,
        .CURSOR_COLOR   (16'hF800)
`endif
    ) dut (
        .bus          (sbus),
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done)
`ifdef CURSOR_OVERLAY_EN
        ,
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .cursor_valid (cursor_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM model: data one cycle after the address
    always @(posedge clk) sbus.vram_rd_data <= vram_mem[sbus.vram_rd_addr];

    function automatic logic [15:0] exp_pix(input int a);
`ifdef CURSOR_OVERLAY_EN
        if (((a % W) == 1) || ((a / W) == 2)) return 16'hF800;
`endif
        return 16'(a);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, got, exp);
        end
    endtask

    task automatic run_row(input int r, input vec_t v);
        int          fv_cyc   = 0;
        int          done_cyc = 0;
        int          done_cnt = 0;
        int          max_cnt  = 0;
        bit          stalled  = 0;
        bit          aborted  = 0;
        logic [17:0] prev     = '0;
        logic [17:0] got;
        logic [17:0] exp;

        for (int a = 0; a < NPIX; a++) begin
            sb.push_back({exp_pix(a), (a == 0), (a == NPIX - 1)});
        end

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        for (int c = 1; c <= NCYC; c++) begin
            sbus.pixel_ready = v.ready_mask[c % 4];
            ena   = !((v.ena_len > 0) && (c >= v.ena_from) && (c < v.ena_from + v.ena_len));
            start = (c == v.repulse_at);
            if (c == v.rst_at) begin
                rstb = 1'b0;
                #1;
                chk("abort_valid", r, 32'(sbus.pixel_valid), 32'd0);
                chk("abort_busy", r, 32'(busy), 32'd0);
            end

            @(negedge clk);
            if (c == 1) chk("busy_after_start", r, 32'(busy), 32'd1);
            if (!ena) chk("ena_hold_addr", r, 32'(sbus.vram_rd_addr), 32'(v.ena_from - 1));
            if (int'(dut.w_count) > max_cnt) max_cnt = int'(dut.w_count);

            got = {sbus.pixel_data, sbus.pixel_first, sbus.pixel_last};
            if (stalled) chk("stall_hold", r, 32'(got), 32'(prev));
            if (sbus.pixel_valid && (fv_cyc == 0)) fv_cyc = c;
            if (sbus.pixel_valid && sbus.pixel_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pix_extra row=%0d got=%0h want=none", r, got);
                end else begin
                    exp = sb.pop_front();
                    chk("pixel", r, 32'(got), 32'(exp));
                end
            end
            stalled = sbus.pixel_valid && !sbus.pixel_ready;
            prev    = got;

            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = c;
            end

            if (c == v.rst_at) begin
                rstb    = 1'b1;
                aborted = 1'b1;
                sb.delete();
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        ena   = 1'b1;
        sbus.pixel_ready = 1'b1;

        chk("done_count", r, 32'(done_cnt), 32'(v.exp_done_cnt));
        if (v.exp_done > 0) chk("done_cycle", r, 32'(done_cyc), 32'(v.exp_done));
        chk("first_valid_cycle", r, 32'(fv_cyc), 32'(v.exp_first));
        chk("fifo_bound", r, 32'(max_cnt <= DEPTH), 32'd1);
        if (!aborted) chk("missing_pixels", r, 32'(sb.size()), 32'd0);
        chk("idle_at_end", r, 32'(busy), 32'd0);
        sb.delete();
    endtask

    initial begin
        //             mask     ena_from len repulse rst first done cnt
        vecs[0] = '{4'b1111, 0, 0, 0, 0, 3, 16, 1};
        vecs[1] = '{4'b1001, 0, 0, 0, 0, 3, 0,  1};
        vecs[2] = '{4'b1111, 6, 5, 0, 0, 3, 21, 1};
        vecs[3] = '{4'b1111, 0, 0, 7, 0, 3, 16, 1};
        vecs[4] = '{4'b1111, 0, 0, 0, 8, 3, 0,  0};
        vecs[5] = '{4'b1111, 0, 0, 0, 0, 3, 16, 1};
        vecs[6] = '{4'b0110, 0, 0, 0, 0, 3, 0,  1};

        for (int a = 0; a < 16; a++) vram_mem[a] = 16'(a);
        rstb             = 1'b0;
        ena              = 1'b1;
        start            = 1'b0;
        cursor_x         = 8'd1;
        cursor_y         = 9'd2;
        cursor_valid     = 1'b1;
        sbus.pixel_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", -1, 32'(busy), 32'd0);
        chk("rst_frame_done", -1, 32'(frame_done), 32'd0);
        chk("rst_valid", -1, 32'(sbus.pixel_valid), 32'd0);
        chk("rst_data", -1, 32'({sbus.pixel_data, sbus.pixel_first, sbus.pixel_last}), 32'd0);
        chk("rst_addr", -1, 32'(sbus.vram_rd_addr), 32'd0);

        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 7; r++) begin
            run_row(r, vecs[r]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
